// File: rtl/dbg_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dbg_apb_pkg
// Purpose : Shared types and widths for the debug APB initiator.
// Rev     : 1.0  initial release
// ============================================================================
package dbg_apb_pkg;

    localparam int DBG_APB_ADDR_W  = 5;
    localparam int DBG_APB_WDATA_W = 32;
    localparam int DBG_APB_RDATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dbg_apb_state_e;

    typedef struct packed {
        logic                       wr_rd;
        logic [DBG_APB_ADDR_W-1:0]  addr;
        logic [DBG_APB_WDATA_W-1:0] wdata;
    } dbg_apb_cmd_t;

    typedef struct packed {
        logic                       err;
        logic [DBG_APB_RDATA_W-1:0] rdata;
    } dbg_apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/dbg_apb_timeout.sv
`default_nettype none
// ============================================================================
// Module  : dbg_apb_timeout
// Purpose : Saturating ACCESS-phase cycle counter; TIMEOUT_CYCLES=0 disables.
// Rev     : 1.0  initial release
// ============================================================================
module dbg_apb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = '1;

            logic [CNT_W-1:0] count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    count <= '0;
                end else if (count_en && (count != CNT_MAX)) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == CNT_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dbg_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module  : dbg_apb_initiator
// Purpose : Valid/ready command channel to single-outstanding APB master.
// Rev     : 1.0  initial release
// ============================================================================
module dbg_apb_initiator
    import dbg_apb_pkg::*;
#(
    parameter int DBG_APB_ADDR_WIDTH  = DBG_APB_ADDR_W,
    parameter int DBG_APB_WDATA_WIDTH = DBG_APB_WDATA_W,
    parameter int DBG_APB_RDATA_WIDTH = DBG_APB_RDATA_W,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_wr_rd,
    input  logic [DBG_APB_ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DBG_APB_WDATA_WIDTH-1:0] cmd_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DBG_APB_RDATA_WIDTH-1:0] rsp_rdata,
    output logic                           rsp_err,
    output logic [DBG_APB_ADDR_WIDTH-1:0]  dbg_apb_addr,
    output logic                           dbg_apb_sel,
    output logic                           dbg_apb_enable,
    output logic                           dbg_apb_wr_rd,
    output logic [DBG_APB_WDATA_WIDTH-1:0] dbg_apb_wdata,
    input  logic                           dbg_apb_ready,
    input  logic [DBG_APB_RDATA_WIDTH-1:0] dbg_apb_rdata
);

    dbg_apb_state_e state, state_next;

    logic                           sel_next;
    logic                           enable_next;
    logic [DBG_APB_ADDR_WIDTH-1:0]  addr_next;
    logic                           wr_rd_next;
    logic [DBG_APB_WDATA_WIDTH-1:0] wdata_next;
    logic                           rsp_valid_next;
    logic                           rsp_err_next;
    logic [DBG_APB_RDATA_WIDTH-1:0] rsp_rdata_next;
    logic                           timeout_expired;

    dbg_apb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == SETUP),
        .count_en ((state == ACCESS) && !dbg_apb_ready),
        .expired  (timeout_expired)
    );

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dbg_apb_sel    <= 1'b0;
            dbg_apb_enable <= 1'b0;
            dbg_apb_addr   <= '0;
            dbg_apb_wr_rd  <= 1'b0;
            dbg_apb_wdata  <= '0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
        end else begin
            state          <= state_next;
            dbg_apb_sel    <= sel_next;
            dbg_apb_enable <= enable_next;
            dbg_apb_addr   <= addr_next;
            dbg_apb_wr_rd  <= wr_rd_next;
            dbg_apb_wdata  <= wdata_next;
            rsp_valid      <= rsp_valid_next;
            rsp_err        <= rsp_err_next;
            rsp_rdata      <= rsp_rdata_next;
        end
    end

    // Slave ready takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (dbg_apb_ready || timeout_expired) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_next       = dbg_apb_sel;
        enable_next    = dbg_apb_enable;
        addr_next      = dbg_apb_addr;
        wr_rd_next     = dbg_apb_wr_rd;
        wdata_next     = dbg_apb_wdata;
        rsp_valid_next = rsp_valid;
        rsp_err_next   = rsp_err;
        rsp_rdata_next = rsp_rdata;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next   = cmd_addr;
                    wr_rd_next  = cmd_wr_rd;
                    wdata_next  = cmd_wdata;
                    sel_next    = 1'b1;
                    enable_next = 1'b0;
                end
            end
            SETUP: begin
                enable_next = 1'b1;
            end
            ACCESS: begin
                if (dbg_apb_ready) begin
                    rsp_rdata_next = dbg_apb_wr_rd ? '0 : dbg_apb_rdata;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    sel_next       = 1'b0;
                    enable_next    = 1'b0;
                end else if (timeout_expired) begin
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    sel_next       = 1'b0;
                    enable_next    = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) rsp_valid_next = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dbg_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_dbg_apb_initiator
// Purpose : Randomised self-checking bench against a memory-based reference.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dbg_apb_initiator;
    import dbg_apb_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr_rd = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  dbg_apb_addr;
    logic        dbg_apb_sel;
    logic        dbg_apb_enable;
    logic        dbg_apb_wr_rd;
    logic [31:0] dbg_apb_wdata;
    logic        dbg_apb_ready = 1'b0;
    logic [31:0] dbg_apb_rdata = '0;

    logic [31:0] ref_mem   [32];
    logic [31:0] slave_mem [32];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dbg_apb_initiator #(
        .DBG_APB_ADDR_WIDTH  (5),
        .DBG_APB_WDATA_WIDTH (32),
        .DBG_APB_RDATA_WIDTH (32),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wr_rd      (cmd_wr_rd),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .dbg_apb_addr   (dbg_apb_addr),
        .dbg_apb_sel    (dbg_apb_sel),
        .dbg_apb_enable (dbg_apb_enable),
        .dbg_apb_wr_rd  (dbg_apb_wr_rd),
        .dbg_apb_wdata  (dbg_apb_wdata),
        .dbg_apb_ready  (dbg_apb_ready),
        .dbg_apb_rdata  (dbg_apb_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic dbg_apb_cmd_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d);
        dbg_apb_cmd_t c;
        c.wr_rd = wr;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    // One transfer: slave raises ready in ACCESS cycle wait_n (never if >= TO),
    // consumer holds off the response for bp cycles.
    task automatic run_txn(input dbg_apb_cmd_t c, input int wait_n, input int bp);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        wr_hit;
        logic [4:0]  wa;
        logic [31:0] wd;
        exp_err   = (wait_n >= TO);
        exp_rdata = (exp_err || c.wr_rd) ? 32'h0 : ref_mem[c.addr];
        if (!exp_err && c.wr_rd) ref_mem[c.addr] = c.wdata;
        wr_hit = 1'b0;
        wa     = '0;
        wd     = '0;

        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_wr_rd = c.wr_rd;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wr_rd = 1'($urandom);
        cmd_addr  = 5'($urandom);
        cmd_wdata = $urandom;
        check("setup_sel", dbg_apb_sel, 1);
        check("setup_enable", dbg_apb_enable, 0);
        check("setup_addr", dbg_apb_addr, c.addr);
        check("setup_wr_rd", dbg_apb_wr_rd, c.wr_rd);
        check("setup_wdata", dbg_apb_wdata, c.wdata);
        check("setup_cmd_ready", cmd_ready, 0);

        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check("access_sel", dbg_apb_sel, 1);
            check("access_enable", dbg_apb_enable, 1);
            check("access_addr", dbg_apb_addr, c.addr);
            check("access_wr_rd", dbg_apb_wr_rd, c.wr_rd);
            check("access_wdata", dbg_apb_wdata, c.wdata);
            check("access_rsp_valid", rsp_valid, 0);
            if (k == wait_n) begin
                dbg_apb_ready = 1'b1;
                dbg_apb_rdata = slave_mem[dbg_apb_addr];
                wr_hit = dbg_apb_wr_rd;
                wa     = dbg_apb_addr;
                wd     = dbg_apb_wdata;
                break;
            end
            dbg_apb_rdata = $urandom;
        end

        @(negedge clk);
        dbg_apb_ready = 1'b0;
        dbg_apb_rdata = $urandom;
        if (wr_hit) slave_mem[wa] = wd;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_sel_low", dbg_apb_sel, 0);
        check("rsp_enable_low", dbg_apb_enable, 0);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rdata);

        rsp_ready = (bp == 0);
        cmd_valid = (bp > 0);
        for (int i = 0; i < bp; i++) begin
            cmd_wr_rd = 1'($urandom);
            cmd_addr  = 5'($urandom);
            cmd_wdata = $urandom;
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_err", rsp_err, exp_err);
            check("bp_rsp_rdata", rsp_rdata, exp_rdata);
            check("bp_sel", dbg_apb_sel, 0);
            if (i == bp - 1) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
    endtask

    task automatic reset_in_access(input dbg_apb_cmd_t c);
        cmd_valid = 1'b1;
        cmd_wr_rd = c.wr_rd;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_enable", dbg_apb_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_sel", dbg_apb_sel, 0);
        check("rst_enable", dbg_apb_enable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_addr", dbg_apb_addr, 0);
        check("rst_wr_rd", dbg_apb_wr_rd, 0);
        check("rst_wdata", dbg_apb_wdata, 0);
        @(negedge clk);
        check("rst_after_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]   = 32'h0;
            slave_mem[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("reset_sel", dbg_apb_sel, 0);
        check("reset_enable", dbg_apb_enable, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_addr", dbg_apb_addr, 0);
        check("reset_wdata", dbg_apb_wdata, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        run_txn(mk(1'b1, 5'h03, 32'hDEADBEEF), 0, 0);
        run_txn(mk(1'b0, 5'h03, 32'h12345678), 0, 0);
        run_txn(mk(1'b1, 5'h05, 32'hA5A5_0F0F), 3, 0);
        run_txn(mk(1'b0, 5'h05, 32'h0), 3, 0);
        run_txn(mk(1'b0, 5'h03, 32'h0), 20, 0);
        run_txn(mk(1'b1, 5'h07, 32'hCAFE_F00D), TO, 0);
        run_txn(mk(1'b0, 5'h07, 32'h0), 1, 0);
        run_txn(mk(1'b1, 5'h09, 32'h0BAD_C0DE), TO - 1, 0);
        run_txn(mk(1'b0, 5'h09, 32'h0), TO - 1, 0);
        run_txn(mk(1'b0, 5'h03, 32'h0), 0, 5);
        reset_in_access(mk(1'b1, 5'h03, 32'h1111_2222));
        run_txn(mk(1'b0, 5'h03, 32'h0), 0, 0);

        for (int n = 0; n < 60; n++) begin
            run_txn(mk(1'($urandom), 5'($urandom_range(0, 7)), $urandom),
                    int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
